// File: rtl/demux_dispatch.sv
// demux_dispatch: show-ahead queue that feeds {a, select} pairs to a DEMUX.
// Optional zero-latency bypass when empty: define DEMUX_DISPATCH_BYPASS_EN.
module demux_dispatch #(
    parameter int N = 2,
    parameter int S = 1,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_a,
    input  logic [S-1:0]         in_select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         a,
    output logic [S-1:0]         select,
    output logic [$clog2(D):0]   count
);

    localparam int PW = $clog2(D);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [N-1:0] a;
        logic [S-1:0] sel;
    } entry_t;

    entry_t          mem_q [D];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            full;
    logic            empty;
    logic            bypass;
    logic            push;
    logic            pop;
    entry_t          head;

    assign full     = (count_q == CW'(D));
    assign empty    = (count_q == '0);
    assign in_ready = ~full;
    assign count    = count_q;
    assign head     = mem_q[rd_ptr_q];

`ifdef DEMUX_DISPATCH_BYPASS_EN
    // An empty queue hands the incoming word straight to the consumer.
    assign bypass = rst_n & empty & in_valid & out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed on the spot and never stored.
    assign push      = in_valid & in_ready & ~bypass;
    assign pop       = ~empty & out_ready;
    assign out_valid = ~empty | bypass;

    // Present the head entry, the bypassed input, or zeros when idle.
    always_comb begin
        a      = '0;
        select = '0;
        if (!empty) begin
            a      = head.a;
            select = head.sel;
        end else if (bypass) begin
            a      = in_a;
            select = in_select;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally (D is 2**PW).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared asynchronously so stored entries are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{a: in_a, sel: in_select};
        end
    end

endmodule
